fft_stage_sequencer: RTL and testbench

Top-level sequencer for the in-place radix-2 DIT FFT built around one shared butterfly unit that computes X1 + W·X2 and X1 − W·X2 with pipelined FP multiply, add and subtract cores.
- Walks all LOG2N stages and SIZE/2 butterflies per stage.
- Generates dual-port data-RAM addresses and the twiddle (SIN/COS) ROM address.
- Launches the butterfly and waits for it to complete.
- Writes the results back in place.
- Input data must already be in bit-reversed order in the RAM.

---
 rtl/fft_stage_sequencer.sv | 113 +++++++++++
 tb/tb_fft_stage_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: walks stages/butterflies of an in-place radix-2 DIT FFT around one shared butterfly unit
module fft_stage_sequencer #(
    parameter int SIZE = 64,
    parameter int LOG2N = 6,
    parameter int BF_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     ram_rd_en,
    output logic                     ram_wr_en,
    output logic [LOG2N-1:0]         addr_a,
    output logic [LOG2N-1:0]         addr_b,
    output logic [LOG2N-2:0]         tw_addr,
    output logic                     bf_start,
    input  logic                     bf_done,
    output logic [$clog2(LOG2N)-1:0] stage
);
    localparam int SW = $clog2(LOG2N);
    localparam int KW = $clog2(SIZE) - 1;
    localparam int TW = $clog2(BF_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT_RD, LAUNCH, WAIT_BF, WRITE, NEXT, DONE} state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [TW-1:0] cnt;

    // Returns {addr_a, addr_b, tw_addr} for butterfly kv of stage sv
    function automatic logic [3*LOG2N-2:0] addrs(input logic [SW-1:0] sv, input logic [KW-1:0] kv);
        logic [LOG2N-1:0] h, j, a;
        h = LOG2N'(1) << sv;
        j = LOG2N'(kv) & (h - 1'b1);
        a = (((LOG2N'(kv) >> sv) << sv) << 1) | j;
        return {a, a | h, (LOG2N-1)'(j << (LOG2N - 1 - sv))};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stage     <= '0;
            k         <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ram_rd_en <= 1'b0;
            ram_wr_en <= 1'b0;
            bf_start  <= 1'b0;
            addr_a    <= '0;
            addr_b    <= '0;
            tw_addr   <= '0;
        end else begin
            ram_rd_en <= 1'b0;
            ram_wr_en <= 1'b0;
            bf_start  <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    stage                     <= '0;
                    k                         <= '0;
                    {addr_a, addr_b, tw_addr} <= addrs('0, '0);
                    err                       <= 1'b0;
                    busy                      <= 1'b1;
                    ram_rd_en                 <= 1'b1;
                    state                     <= READ;
                end
                READ: state <= WAIT_RD;
                WAIT_RD: begin
                    bf_start <= 1'b1;
                    state    <= LAUNCH;
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT_BF;
                end
                // bf_done is tested first so it wins over a coincident timeout
                WAIT_BF: if (bf_done) begin
                    ram_wr_en <= 1'b1;
                    state     <= WRITE;
                end else if (cnt == TW'(BF_TIMEOUT - 1)) begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                WRITE: state <= NEXT;
                NEXT: if (k != KW'(SIZE / 2 - 1)) begin
                    k                         <= k + 1'b1;
                    {addr_a, addr_b, tw_addr} <= addrs(stage, k + 1'b1);
                    ram_rd_en                 <= 1'b1;
                    state                     <= READ;
                end else if (stage != SW'(LOG2N - 1)) begin
                    stage                     <= stage + 1'b1;
                    k                         <= '0;
                    {addr_a, addr_b, tw_addr} <= addrs(stage + 1'b1, '0);
                    ram_rd_en                 <= 1'b1;
                    state                     <= READ;
                end else begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed checks on an 8-point instance (addresses, handshake, timeout, reset)
// and a 64-point instance driving a behavioural butterfly and RAM.
module tb_fft_stage_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    logic       start8 = 1'b0, busy8, done8, err8, rd8, wr8, bs8, bfd8, stray8 = 1'b0;
    logic [2:0] aa8, ab8;
    logic [1:0] tw8, st8;
    logic       bfm8 = 1'b0;
    int         lat8 = 3;
    int         rem8 = 0;

    assign bfd8 = bfm8 | stray8;

    fft_stage_sequencer #(.SIZE(8), .LOG2N(3), .BF_TIMEOUT(255)) u8 (
        .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8), .err(err8),
        .ram_rd_en(rd8), .ram_wr_en(wr8), .addr_a(aa8), .addr_b(ab8), .tw_addr(tw8),
        .bf_start(bs8), .bf_done(bfd8), .stage(st8)
    );

    // Butterfly latency model: bf_done is high exactly lat8 cycles after the bf_start cycle (lat8=0: never)
    always @(negedge clk) begin
        if (rem8 > 0) begin
            rem8--;
            bfm8 = (rem8 == 0);
        end else begin
            bfm8 = 1'b0;
        end
        if (bs8 && lat8 > 0) rem8 = lat8;
    end

    logic       start64 = 1'b0, busy64, done64, err64, rd64, wr64, bs64, bfd64 = 1'b0;
    logic [5:0] aa64, ab64;
    logic [4:0] tw64;
    logic [2:0] st64;
    real        rr[64], ri[64];
    real        x1r, x1i, x2r, x2i, f0r, f0i, f1r, f1i, cw, sw;
    int         rem64 = 0, nbf = 0, req64 = 0, seen64 = 0, pat64 = 0;

    fft_stage_sequencer #(.SIZE(64), .LOG2N(6), .BF_TIMEOUT(255)) u64 (
        .clk(clk), .rst(rst), .start(start64), .busy(busy64), .done(done64), .err(err64),
        .ram_rd_en(rd64), .ram_wr_en(wr64), .addr_a(aa64), .addr_b(ab64), .tw_addr(tw64),
        .bf_start(bs64), .bf_done(bfd64), .stage(st64)
    );

    // Behavioural RAM + twiddle ROM + butterfly (latency 2) for the 64-point instance
    always @(negedge clk) begin
        if (req64 != seen64) begin
            seen64 = req64;
            nbf = 0;
            for (int i = 0; i < 64; i++) begin
                rr[i] = (pat64 == 0) ? ((i == 0) ? 1.0 : 0.0) : 1.0;
                ri[i] = 0.0;
            end
        end
        bfd64 = 1'b0;
        if (rem64 > 0) begin
            rem64--;
            bfd64 = (rem64 == 0);
        end
        if (rd64) begin
            x1r = rr[aa64];
            x1i = ri[aa64];
            x2r = rr[ab64];
            x2i = ri[ab64];
            cw = $cos(2.0 * 3.14159265358979 * tw64 / 64.0);
            sw = -$sin(2.0 * 3.14159265358979 * tw64 / 64.0);
        end
        if (bs64) begin
            f0r = x1r + (cw * x2r - sw * x2i);
            f0i = x1i + (cw * x2i + sw * x2r);
            f1r = x1r - (cw * x2r - sw * x2i);
            f1i = x1i - (cw * x2i + sw * x2r);
            rem64 = 2;
            nbf++;
        end
        if (wr64) begin
            rr[aa64] = f0r;
            ri[aa64] = f0i;
            rr[ab64] = f1r;
            ri[ab64] = f1i;
        end
    end

    int ea[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int eb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int et[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    task automatic run8(input int L, input bit poke);
        int cs, pk, rdc, bsc, idx, bad;
        logic [9:0] cur, held, exp;
        bit fin, inrun;
        lat8 = L;
        idx = 0;
        bad = 0;
        rdc = -100;
        bsc = -100;
        fin = 1'b0;
        inrun = 1'b0;
        held = '0;
        if (poke) begin
            @(negedge clk);
            stray8 = 1'b1;
            @(negedge clk);
            stray8 = 1'b0;
            check("stray_idle", {busy8, rd8}, 0);
        end
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cs = cyc - 1;
        pk = cs + int'($urandom_range(5, 90));
        check("err_clear", err8, 0);
        check("busy_on", busy8, 1);
        for (int n = 0; n < 12 * (L + 5) + 20 && !fin; n++) begin
            cur = {st8, aa8, ab8, tw8};
            if (rd8) begin
                rdc = cyc;
                held = cur;
                inrun = 1'b1;
                if (poke && idx == 5) stray8 = 1'b1;
            end else begin
                stray8 = 1'b0;
            end
            if (inrun && cur !== held) bad++;
            if (bs8) begin
                bsc = cyc;
                if (cyc - rdc != 2) bad++;
            end
            if (wr8) begin
                if (cyc - bsc != L + 1) bad++;
                if (idx < 12) begin
                    exp = {2'(idx / 4), 3'(ea[idx]), 3'(eb[idx]), 2'(et[idx])};
                    check($sformatf("addr%0d_L%0d", idx, L), cur, exp);
                end
                idx++;
                inrun = 1'b0;
            end
            if (done8) begin
                fin = 1'b1;
                check($sformatf("done_cycle_L%0d", L), cyc - cs, 12 * (L + 5) + 1);
                if (wr8 || busy8) bad++;
            end else if (!busy8) begin
                bad++;
            end
            if (poke) start8 = (cyc == pk);
            @(negedge clk);
        end
        stray8 = 1'b0;
        start8 = 1'b0;
        check($sformatf("done_seen_L%0d", L), fin, 1);
        check($sformatf("writes_L%0d", L), idx, 12);
        check($sformatf("handshake_L%0d", L), bad, 0);
        check($sformatf("no_err_L%0d", L), err8, 0);
    endtask

    task automatic run64(input int pat);
        pat64 = pat;
        req64++;
        repeat (2) @(negedge clk);
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        for (int n = 0; n < 1500 && !done64; n++) @(negedge clk);
        check($sformatf("done64_p%0d", pat), done64, 1);
        @(negedge clk);
        check($sformatf("nbf_p%0d", pat), nbf, 192);
        check($sformatf("err64_p%0d", pat), err64, 0);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("x%0d_re_p%0d", i, pat), longint'(rr[i] * 1024.0),
                  (pat == 0) ? 1024 : ((i == 0) ? 65536 : 0));
            check($sformatf("x%0d_im_p%0d", i, pat), longint'(ri[i] * 1024.0), 0);
        end
    endtask

    initial begin
        int bsc, errc, wrs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset8", {busy8, done8, err8, rd8, wr8, aa8, ab8, tw8, bs8, st8}, 0);
        check("reset64", {busy64, done64, err64, rd64, wr64, aa64, ab64, tw64, bs64, st64}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run8(3, 1'b0);
        run8(1, 1'b0);
        run8(7, 1'b0);
        run8(20, 1'b0);

        // Butterfly never answers: expect timeout with no write and no done
        lat8 = 0;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        bsc = -1;
        for (int n = 0; n < 20 && bsc < 0; n++) begin
            if (bs8) bsc = cyc;
            @(negedge clk);
        end
        check("to_launch", bsc >= 0, 1);
        errc = -1;
        wrs = 0;
        for (int n = 0; n < 300 && errc < 0; n++) begin
            if (wr8 || done8) wrs++;
            if (err8) errc = cyc;
            @(negedge clk);
        end
        check("to_err_cycle", errc - bsc, 256);
        check("to_busy", busy8, 0);
        check("to_no_write", wrs, 0);
        repeat (5) @(negedge clk);
        check("err_sticky", err8, 1);
        run8(3, 1'b0);

        // bf_done landing on the timeout cycle must still complete
        run8(255, 1'b0);
        run8(3, 1'b1);

        // Reset during a stage-2 WAIT_BF
        lat8 = 3;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int n = 0; n < 200 && !(bs8 && st8 == 2'd2); n++) @(negedge clk);
        check("rst_reach", bs8 && st8 == 2'd2, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", {busy8, done8, err8, rd8, wr8, aa8, ab8, tw8, bs8, st8}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        run8(3, 1'b0);

        run64(0);
        run64(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
